// File: rtl/timebase_pkg.sv
// Shared state encoding and default timing for the timebase controller.
package timebase_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPend
  } tb_state_e;

  localparam int unsigned DefNbt   = 50000000;
  localparam int unsigned DefNbton = 25000000;

endpackage

// File: rtl/period_counter.sv
// Period counter with registered divided-clock and end-of-period tick outputs.
module period_counter #(
  parameter int unsigned Width    = 32,
  parameter bit          Polarity = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [Width-1:0] nbt_i,
  input  logic [Width-1:0] nbton_i,
  output logic             last_o,
  output logic             clkout_o,
  output logic             tick_o
);

  logic [Width-1:0] cnt_q;
  logic             clkout_q;
  logic             tick_q;

  // >= rather than == keeps the counter bounded if the period ever shrinks under it.
  assign last_o   = (cnt_q >= (nbt_i - Width'(1)));
  assign clkout_o = clkout_q;
  assign tick_o   = tick_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || !en_i) begin
      cnt_q    <= '0;
      clkout_q <= Polarity;
      tick_q   <= 1'b0;
    end else begin
      clkout_q <= (cnt_q < nbton_i) ? Polarity : ~Polarity;
      tick_q   <= last_o;
      cnt_q    <= last_o ? '0 : cnt_q + Width'(1);
    end
  end

endmodule

// File: rtl/timebase_ctrl.sv
// Run/stop FSM and configuration handshake around a programmable period counter.
module timebase_ctrl
  import timebase_pkg::*;
#(
  parameter int unsigned BUS_SIZE  = 32,
  parameter int unsigned DEF_NBT   = DefNbt,
  parameter int unsigned DEF_NBTON = DefNbton,
  parameter bit          POLARITY  = 1'b0
) (
  input  logic                Clkin,
  input  logic                Rstn,
  input  logic                Start,
  input  logic                Stop,
  input  logic                CfgValid,
  input  logic [BUS_SIZE-1:0] CfgNbt,
  input  logic [BUS_SIZE-1:0] CfgNbton,
  output logic                CfgReady,
  output logic                CfgErr,
  output logic                Clkout,
  output logic                Tick,
  output logic                Running
);

  tb_state_e           state_q;
  logic [BUS_SIZE-1:0] nbt_q, nbton_q;
  logic [BUS_SIZE-1:0] sh_nbt_q, sh_nbton_q;
  logic                cfg_err_q;
  logic                cfg_fire, cfg_good;
  logic                cnt_last, cnt_en;

  assign CfgReady = (state_q != StPend);
  assign Running  = (state_q != StIdle);
  assign CfgErr   = cfg_err_q;
  assign cfg_fire = CfgValid & CfgReady;
  assign cfg_good = (CfgNbt >= BUS_SIZE'(2)) && (CfgNbton != '0) && (CfgNbton < CfgNbt);
  // Stop clears the counter on the same edge that returns the FSM to idle.
  assign cnt_en   = Running & ~Stop;

  always_ff @(posedge Clkin) begin
    if (!Rstn) begin
      state_q    <= StIdle;
      nbt_q      <= BUS_SIZE'(DEF_NBT);
      nbton_q    <= BUS_SIZE'(DEF_NBTON);
      sh_nbt_q   <= '0;
      sh_nbton_q <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      cfg_err_q <= cfg_fire & ~cfg_good;
      unique case (state_q)
        StIdle: begin
          if (cfg_fire && cfg_good) begin
            nbt_q   <= CfgNbt;
            nbton_q <= CfgNbton;
          end
          if (Start && !Stop) state_q <= StRun;
        end
        StRun: begin
          if (Stop) begin
            state_q <= StIdle;
            if (cfg_fire && cfg_good) begin
              nbt_q   <= CfgNbt;
              nbton_q <= CfgNbton;
            end
          end else if (cfg_fire && cfg_good) begin
            sh_nbt_q   <= CfgNbt;
            sh_nbton_q <= CfgNbton;
            state_q    <= StPend;
          end
        end
        StPend: begin
          if (Stop || cnt_last) begin
            nbt_q   <= sh_nbt_q;
            nbton_q <= sh_nbton_q;
            state_q <= Stop ? StIdle : StRun;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  period_counter #(
    .Width   (BUS_SIZE),
    .Polarity(POLARITY)
  ) u_period_counter (
    .clk_i   (Clkin),
    .rst_ni  (Rstn),
    .en_i    (cnt_en),
    .nbt_i   (nbt_q),
    .nbton_i (nbton_q),
    .last_o  (cnt_last),
    .clkout_o(Clkout),
    .tick_o  (Tick)
  );

endmodule

// File: tb/tb_timebase_ctrl.sv
// Directed bench: two instances (POLARITY 0 and 1) sharing stimulus, defaults NBT=4, NBTON=2.
module tb_timebase_ctrl;

  logic        Clkin, Rstn, Start, Stop, CfgValid;
  logic [31:0] CfgNbt, CfgNbton;
  logic        CfgReady, CfgErr, Clkout, Tick, Running;
  logic        CfgReady_p, CfgErr_p, Clkout_p, Tick_p, Running_p;

  int nvec = 0;
  int nerr = 0;

  // Reference period model
  int mcnt, mnbt, mnbton, pnbt, pnbton;
  bit pend;

  timebase_ctrl #(
    .BUS_SIZE (32),
    .DEF_NBT  (4),
    .DEF_NBTON(2),
    .POLARITY (1'b0)
  ) dut (
    .Clkin   (Clkin),
    .Rstn    (Rstn),
    .Start   (Start),
    .Stop    (Stop),
    .CfgValid(CfgValid),
    .CfgNbt  (CfgNbt),
    .CfgNbton(CfgNbton),
    .CfgReady(CfgReady),
    .CfgErr  (CfgErr),
    .Clkout  (Clkout),
    .Tick    (Tick),
    .Running (Running)
  );

  timebase_ctrl #(
    .BUS_SIZE (32),
    .DEF_NBT  (4),
    .DEF_NBTON(2),
    .POLARITY (1'b1)
  ) dut_p (
    .Clkin   (Clkin),
    .Rstn    (Rstn),
    .Start   (Start),
    .Stop    (Stop),
    .CfgValid(CfgValid),
    .CfgNbt  (CfgNbt),
    .CfgNbton(CfgNbton),
    .CfgReady(CfgReady_p),
    .CfgErr  (CfgErr_p),
    .Clkout  (Clkout_p),
    .Tick    (Tick_p),
    .Running (Running_p)
  );

  initial begin
    Clkin = 1'b0;
    forever #5 Clkin = ~Clkin;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clkin);
    #1;
  endtask

  // One running cycle checked against the model.
  task automatic cyc();
    logic exp_clk, exp_tick;
    exp_clk  = (mcnt >= mnbton);
    exp_tick = (mcnt == mnbt - 1);
    if (mcnt == mnbt - 1) begin
      mcnt = 0;
      if (pend) begin
        mnbt   = pnbt;
        mnbton = pnbton;
        pend   = 1'b0;
      end
    end else begin
      mcnt++;
    end
    step();
    chk("clkout", {31'd0, Clkout}, {31'd0, exp_clk});
    chk("tick", {31'd0, Tick}, {31'd0, exp_tick});
    chk("clkout_pol1", {31'd0, Clkout_p}, {31'd0, ~exp_clk});
    chk("running", {31'd0, Running}, 32'd1);
  endtask

  task automatic start_run(input int nbt, input int nbton);
    Start = 1'b1;
    step();
    Start  = 1'b0;
    mcnt   = 0;
    mnbt   = nbt;
    mnbton = nbton;
    pend   = 1'b0;
    chk("start_running", {31'd0, Running}, 32'd1);
    chk("start_clkout_idle", {31'd0, Clkout}, 32'd0);
  endtask

  initial begin
    Rstn = 1'b0; Start = 1'b0; Stop = 1'b0; CfgValid = 1'b0;
    CfgNbt = '0; CfgNbton = '0;
    mcnt = 0; mnbt = 4; mnbton = 2; pnbt = 0; pnbton = 0; pend = 1'b0;
    step();
    step();
    chk("rst_running", {31'd0, Running}, 32'd0);
    chk("rst_clkout", {31'd0, Clkout}, 32'd0);
    chk("rst_clkout_pol1", {31'd0, Clkout_p}, 32'd1);
    chk("rst_tick", {31'd0, Tick}, 32'd0);
    chk("rst_cfgerr", {31'd0, CfgErr}, 32'd0);
    Rstn = 1'b1;
    step();
    chk("rel_cfgready", {31'd0, CfgReady}, 32'd1);
    chk("idle_clkout", {31'd0, Clkout}, 32'd0);

    // Default period 4/2: 0,0,1,1 with tick every 4th cycle
    start_run(4, 2);
    for (int i = 0; i < 8; i++) cyc();

    // (6,3) offered mid-period: old period finishes first
    cyc();
    CfgValid = 1'b1; CfgNbt = 32'd6; CfgNbton = 32'd3;
    chk("cfg_ready_run", {31'd0, CfgReady}, 32'd1);
    cyc();
    CfgValid = 1'b0;
    pend = 1'b1; pnbt = 6; pnbton = 3;
    chk("cfg_ready_pend", {31'd0, CfgReady}, 32'd0);
    cyc();
    cyc();
    chk("cfg_ready_applied", {31'd0, CfgReady}, 32'd1);
    for (int i = 0; i < 6; i++) cyc();

    // Rejected configurations leave the running period untouched
    for (int k = 0; k < 3; k++) begin
      CfgValid = 1'b1;
      CfgNbt   = (k == 0) ? 32'd3 : (k == 1) ? 32'd1 : 32'd5;
      CfgNbton = (k == 0) ? 32'd3 : 32'd0;
      cyc();
      CfgValid = 1'b0;
      chk("cfgerr_pulse", {31'd0, CfgErr}, 32'd1);
      chk("cfgerr_ready", {31'd0, CfgReady}, 32'd1);
      cyc();
      chk("cfgerr_clear", {31'd0, CfgErr}, 32'd0);
    end
    for (int i = 0; i < 6; i++) cyc();

    // Start and Stop together in RUN: Stop wins
    cyc();
    Start = 1'b1; Stop = 1'b1;
    step();
    Start = 1'b0; Stop = 1'b0;
    chk("stop_running", {31'd0, Running}, 32'd0);
    chk("stop_clkout", {31'd0, Clkout}, 32'd0);
    chk("stop_clkout_pol1", {31'd0, Clkout_p}, 32'd1);
    chk("stop_tick", {31'd0, Tick}, 32'd0);
    step();
    chk("stop_stays_idle", {31'd0, Running}, 32'd0);

    // Valid config alongside Stop applies as in idle
    start_run(6, 3);
    cyc();
    cyc();
    Stop = 1'b1; CfgValid = 1'b1; CfgNbt = 32'd3; CfgNbton = 32'd1;
    step();
    Stop = 1'b0; CfgValid = 1'b0;
    chk("stopcfg_running", {31'd0, Running}, 32'd0);
    chk("stopcfg_cfgerr", {31'd0, CfgErr}, 32'd0);
    start_run(3, 1);
    for (int i = 0; i < 6; i++) cyc();

    // Reset while PEND: shadow lost, defaults restored
    cyc();
    CfgValid = 1'b1; CfgNbt = 32'd5; CfgNbton = 32'd2;
    cyc();
    CfgValid = 1'b0;
    chk("pend_ready", {31'd0, CfgReady}, 32'd0);
    Rstn = 1'b0;
    step();
    chk("pendrst_running", {31'd0, Running}, 32'd0);
    chk("pendrst_tick", {31'd0, Tick}, 32'd0);
    chk("pendrst_cfgerr", {31'd0, CfgErr}, 32'd0);
    chk("pendrst_clkout", {31'd0, Clkout}, 32'd0);
    chk("pendrst_clkout_pol1", {31'd0, Clkout_p}, 32'd1);
    Rstn = 1'b1;
    step();
    chk("pendrst_ready", {31'd0, CfgReady}, 32'd1);
    start_run(4, 2);
    for (int i = 0; i < 8; i++) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
